// File: rtl/chip8_video_tiler.sv
// chip8_video_tiler: tiles several CHIP-8 monochrome framebuffers into a centred grid.
// Each tile is scaled, coloured through a per-channel palette, and can carry a cell grid
// overlay and a blinking border on the focused core. Output is a registered RGB pixel.
module chip8_video_tiler #(
    parameter int NUM_CH       = 4,
    parameter int TILE_COLS    = 2,
    parameter int FB_W         = 64,
    parameter int FB_H         = 32,
    parameter int SCALE        = 8,
    parameter int H_ACTIVE     = 1280,
    parameter int V_ACTIVE     = 720,
    parameter int RD_LATENCY   = 2,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [10:0]           hcount_in,
    input  logic [9:0]            vcount_in,
    input  logic                  new_frame_in,
    output logic [15:0]           fb_addr_out,
    input  logic [NUM_CH*8-1:0]   fb_data_in,
    input  logic                  grid_in,
    input  logic [2:0]            focus_in,
    input  logic                  pal_we_in,
    input  logic [2:0]            pal_ch_in,
    input  logic [23:0]           pal_rgb_in,
    output logic [7:0]            red_out,
    output logic [7:0]            green_out,
    output logic [7:0]            blue_out
);

    // ------------------------------------------------------------------
    // Geometry
    // ------------------------------------------------------------------
    localparam int ROWS          = (NUM_CH + TILE_COLS - 1) / TILE_COLS;
    localparam int TW            = FB_W * SCALE;
    localparam int TH            = FB_H * SCALE;
    localparam int GRID_W        = TILE_COLS * TW;
    localparam int GRID_H        = ROWS * TH;
    localparam int X0            = (H_ACTIVE - GRID_W) / 2;
    localparam int Y0            = (V_ACTIVE - GRID_H) / 2;
    localparam int SCALE_SH      = $clog2(SCALE);
    localparam int BYTES_PER_ROW = FB_W / 8;
    localparam bit TW_POW2       = (TW & (TW - 1)) == 0;
    localparam bit TH_POW2       = (TH & (TH - 1)) == 0;
    localparam int TW_SH         = $clog2(TW);
    localparam int TH_SH         = $clog2(TH);
    localparam int LX_W          = (TW > 1) ? $clog2(TW) : 1;
    localparam int LY_W          = (TH > 1) ? $clog2(TH) : 1;
    localparam int CNT_W         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [23:0] PAL_DEFAULT = 24'h7FFFD4;
    localparam logic [23:0] GRID_XOR    = 24'h404040;

    // Per-pixel context carried alongside the framebuffer read
    typedef struct packed {
        logic            vld;
        logic [2:0]      ch;
        logic [2:0]      bit_idx;
        logic [LX_W-1:0] lx;
        logic [LY_W-1:0] ly;
    } meta_t;

    // ------------------------------------------------------------------
    // Stage 0: tile decode and framebuffer address
    // ------------------------------------------------------------------
    int          h_pos, v_pos;
    int          x_pos, y_pos;
    int          col, row, ch_idx;
    int          lx_i, ly_i;
    int          fbx, fby;
    logic        in_tile;
    logic        active;
    meta_t       meta_d;
    logic [15:0] addr_d;

    // Decode screen position into tile, local offset and byte address
    always_comb begin
        h_pos = int'(hcount_in);
        v_pos = int'(vcount_in);
        x_pos = h_pos - X0;
        y_pos = v_pos - Y0;

        col = 0;
        row = 0;
        if (TW_POW2) begin
            col = x_pos >>> TW_SH;
        end else begin
            // Compare chain keeps a non power-of-two tile width free of dividers
            for (int c = 1; c < TILE_COLS; c++) begin
                if (x_pos >= c * TW) col = c;
            end
        end
        if (TH_POW2) begin
            row = y_pos >>> TH_SH;
        end else begin
            for (int r = 1; r < ROWS; r++) begin
                if (y_pos >= r * TH) row = r;
            end
        end

        lx_i   = x_pos - col * TW;
        ly_i   = y_pos - row * TH;
        ch_idx = row * TILE_COLS + col;

        active  = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
        in_tile = (x_pos >= 0) && (x_pos < GRID_W) &&
                  (y_pos >= 0) && (y_pos < GRID_H) &&
                  (ch_idx < NUM_CH);

        fbx = lx_i >>> SCALE_SH;
        fby = ly_i >>> SCALE_SH;

        addr_d         = 16'(fby * BYTES_PER_ROW + (fbx >>> 3));
        meta_d.vld     = in_tile && active;
        meta_d.ch      = 3'(ch_idx);
        // MSB of each byte is the leftmost pixel
        meta_d.bit_idx = 3'(7 - (fbx & 7));
        meta_d.lx      = LX_W'(lx_i);
        meta_d.ly      = LY_W'(ly_i);
    end

    // ------------------------------------------------------------------
    // Context pipeline, aligned with the RAM read latency
    // ------------------------------------------------------------------
    meta_t       pipe_q [RD_LATENCY+1];
    logic [15:0] fb_addr_q;

    // Register stage 0 and shift context in step with the framebuffer read
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fb_addr_q <= '0;
            for (int k = 0; k <= RD_LATENCY; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            fb_addr_q <= addr_d;
            pipe_q[0] <= meta_d;
            for (int k = 1; k <= RD_LATENCY; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    assign fb_addr_out = fb_addr_q;

    // ------------------------------------------------------------------
    // Palette
    // ------------------------------------------------------------------
    logic [23:0] pal_q [NUM_CH];

    // Palette registers; writes to channels beyond NUM_CH fall through the decode
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int c = 0; c < NUM_CH; c++) begin
                pal_q[c] <= PAL_DEFAULT;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (pal_we_in && (pal_ch_in == 3'(c))) pal_q[c] <= pal_rgb_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Focus border blink
    // ------------------------------------------------------------------
    logic [2:0]       focus_q;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             phase_q, phase_d;

    // Blink next state; a focus change restarts the blink with the border visible
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (focus_in != focus_q) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (new_frame_in) begin
            if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + CNT_W'(1);
            end
        end
    end

    // Blink state registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            focus_q     <= focus_in;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            focus_q     <= focus_in;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    meta_t       m;
    logic [63:0] data_pad;
    logic [23:0] pal_sel;
    logic [23:0] rgb_d, rgb_q;
    logic        pix_bit;
    logic        border;
    logic        grid_hit;
    int          lx_o, ly_o;

    assign m        = pipe_q[RD_LATENCY];
    assign data_pad = 64'(fb_data_in);

    // Resolve the pixel colour by priority: blank, focus border, palette, grid overlay
    always_comb begin
        lx_o    = int'(m.lx);
        ly_o    = int'(m.ly);
        pix_bit = data_pad[{m.ch, m.bit_idx}];

        pal_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (m.ch == 3'(c)) pal_sel = pal_q[c];
        end

        border   = (lx_o < 2) || (lx_o >= TW - 2) || (ly_o < 2) || (ly_o >= TH - 2);
        grid_hit = ((lx_o & (SCALE - 1)) == 0) || ((ly_o & (SCALE - 1)) == 0);

        rgb_d = '0;
        if (!m.vld) begin
            rgb_d = '0;
        end else if ((m.ch == focus_in) && phase_q && border) begin
            rgb_d = 24'hFFFFFF;
        end else begin
            rgb_d = pix_bit ? pal_sel : 24'h000000;
            if (grid_in && grid_hit) rgb_d = rgb_d ^ GRID_XOR;
        end
    end

    // Output colour register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign red_out   = rgb_q[23:16];
    assign green_out = rgb_q[15:8];
    assign blue_out  = rgb_q[7:0];

endmodule

// File: tb/tb_chip8_video_tiler.sv
// Directed bench for chip8_video_tiler: default 4-channel instance plus a 3-channel instance.
module tb_chip8_video_tiler;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        new_frame;
    logic        grid;
    logic [2:0]  focus;
    logic        pal_we;
    logic [2:0]  pal_ch;
    logic [23:0] pal_rgb;

    logic [15:0] addr4, addr3;
    logic [31:0] fb_data;
    logic [7:0]  r4, g4, b4, r3, g3, b3;

    logic [7:0]  mem [4][256];
    logic [31:0] rd1, rd2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Two-cycle framebuffer RAM model (RAM + output register)
    always @(posedge clk) begin
        rd1 <= {mem[3][addr4[7:0]], mem[2][addr4[7:0]], mem[1][addr4[7:0]], mem[0][addr4[7:0]]};
        rd2 <= rd1;
    end
    assign fb_data = rd2;

    chip8_video_tiler dut4 (
        .clk_in       (clk),
        .rst_in       (rst),
        .hcount_in    (hcount),
        .vcount_in    (vcount),
        .new_frame_in (new_frame),
        .fb_addr_out  (addr4),
        .fb_data_in   (fb_data),
        .grid_in      (grid),
        .focus_in     (focus),
        .pal_we_in    (pal_we),
        .pal_ch_in    (pal_ch),
        .pal_rgb_in   (pal_rgb),
        .red_out      (r4),
        .green_out    (g4),
        .blue_out     (b4)
    );

    chip8_video_tiler #(.NUM_CH(3)) dut3 (
        .clk_in       (clk),
        .rst_in       (rst),
        .hcount_in    (hcount),
        .vcount_in    (vcount),
        .new_frame_in (new_frame),
        .fb_addr_out  (addr3),
        .fb_data_in   (24'hFFFFFF),
        .grid_in      (grid),
        .focus_in     (focus),
        .pal_we_in    (pal_we),
        .pal_ch_in    (pal_ch),
        .pal_rgb_in   (pal_rgb),
        .red_out      (r3),
        .green_out    (g3),
        .blue_out     (b3)
    );

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pix(input int h, input int v);
        hcount = 11'(h);
        vcount = 10'(v);
    endtask

    function automatic logic [23:0] rgb4();
        return {r4, g4, b4};
    endfunction

    function automatic logic [23:0] rgb3();
        return {r3, g3, b3};
    endfunction

    initial begin
        for (int c = 0; c < 4; c++) begin
            for (int a = 0; a < 256; a++) mem[c][a] = 8'h00;
        end
        mem[0][0]   = 8'h80;
        mem[3][255] = 8'h01;
        rst = 1'b1; new_frame = 1'b0; grid = 1'b0; focus = 3'd7;
        pal_we = 1'b0; pal_ch = 3'd0; pal_rgb = 24'h0;
        pix(100, 50);

        // Reset state
        cyc(2);
        check("rst_rgb", rgb4(), 24'h000000);
        check("rst_addr", 24'(addr4), 24'h0);

        rst = 1'b0;
        cyc(6);
        check("outside", rgb4(), 24'h000000);

        // First lit pixel and its latency
        pix(128, 104);
        cyc(3);
        check("lat_t3", rgb4(), 24'h000000);
        cyc(1);
        check("lat_t4", rgb4(), 24'h7FFFD4);
        check("addr0", 24'(addr4), 24'h0);

        pix(136, 104); cyc(5);
        check("px136", rgb4(), 24'h000000);

        // Bottom-right corner of tile 3
        pix(1151, 615); cyc(5);
        check("ch3_rgb", rgb4(), 24'h7FFFD4);
        check("ch3_addr", 24'(addr4), 24'd255);
        check("n3_ch3", rgb3(), 24'h000000);

        pix(1152, 615); cyc(5);
        check("right_edge", rgb4(), 24'h000000);
        pix(127, 103); cyc(5);
        check("top_left_out", rgb4(), 24'h000000);

        pix(128, 104); cyc(5);
        check("n3_ch0", rgb3(), 24'h7FFFD4);

        // Grid overlay
        mem[0][0] = 8'hA0;
        grid = 1'b1;
        pix(144, 104); cyc(5);
        check("grid_lit", rgb4(), 24'h3FBF94);
        pix(144, 112); cyc(5);
        check("grid_unlit", rgb4(), 24'h404040);
        pix(145, 113); cyc(5);
        check("nogrid_unlit", rgb4(), 24'h000000);
        pix(145, 105); cyc(5);
        check("nogrid_lit", rgb4(), 24'h7FFFD4);
        grid = 1'b0;

        // Focus border and blink
        focus = 3'd1;
        pix(640, 104); cyc(5);
        check("focus1_border", rgb4(), 24'hFFFFFF);
        for (int i = 0; i < 31; i++) begin
            new_frame = 1'b1; cyc(1);
            new_frame = 1'b0; cyc(1);
        end
        cyc(4);
        check("blink_31", rgb4(), 24'hFFFFFF);
        new_frame = 1'b1; cyc(1);
        new_frame = 1'b0; cyc(5);
        check("blink_32", rgb4(), 24'h000000);

        focus = 3'd2;
        pix(128, 360); cyc(5);
        check("focus2_corner", rgb4(), 24'hFFFFFF);
        pix(638, 362); cyc(5);
        check("focus2_right", rgb4(), 24'hFFFFFF);
        pix(130, 362); cyc(5);
        check("focus2_inner", rgb4(), 24'h000000);
        pix(640, 104); cyc(5);
        check("focus1_off", rgb4(), 24'h000000);

        // Palette write during a scan
        focus = 3'd7;
        mem[2][8] = 8'h80;
        pix(128, 368); cyc(5);
        check("ch2_pre", rgb4(), 24'h7FFFD4);
        pal_ch = 3'd2; pal_rgb = 24'hFF0000; pal_we = 1'b1;
        cyc(1);
        pal_we = 1'b0;
        check("pal_old", rgb4(), 24'h7FFFD4);
        cyc(1);
        check("pal_new", rgb4(), 24'hFF0000);
        pal_ch = 3'd4; pal_rgb = 24'h000000; pal_we = 1'b1;
        cyc(1);
        pal_we = 1'b0;
        pix(128, 104); cyc(5);
        check("ch0_keep", rgb4(), 24'h7FFFD4);
        pix(128, 368); cyc(5);
        check("ch2_keep", rgb4(), 24'hFF0000);

        // Reset mid-line
        pix(1151, 615); cyc(5);
        rst = 1'b1;
        cyc(1);
        check("rst_mid_rgb", rgb4(), 24'h000000);
        check("rst_mid_addr", 24'(addr4), 24'h0);
        rst = 1'b0;
        cyc(3);
        check("rst_t3", rgb4(), 24'h000000);
        cyc(1);
        check("rst_t4", rgb4(), 24'h7FFFD4);
        pix(128, 368); cyc(5);
        check("pal_reset", rgb4(), 24'h7FFFD4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
